// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared light codes, controller state codes and debounce states
package sig_pkg;

  // Country/highway light code as driven by the controller; code 3 is unused.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  // Controller state codes, shared so both blocks agree on encoding.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Loop debounce FSM states.
  typedef enum logic [1:0] {
    DB_LOW  = 2'd0,
    DB_RISE = 2'd1,
    DB_HIGH = 2'd2,
    DB_FALL = 2'd3
  } db_state_t;

endpackage

// File: rtl/cntry_car_sensor_if.sv
// rtl/cntry_car_sensor_if.sv - loop input, light code and car-waiting outputs
interface cntry_car_sensor_if #(
  parameter int CNT_W = 4
);
  logic             loop;
  logic [1:0]       cntry;
  logic             X;
  logic [CNT_W-1:0] car_count;
  logic             overflow;

  // Sensor side: samples loop and light code, drives the waiting-car outputs.
  modport master (
    input  loop,
    input  cntry,
    output X,
    output car_count,
    output overflow
  );

  // Environment/controller side.
  modport slave (
    output loop,
    output cntry,
    input  X,
    input  car_count,
    input  overflow
  );
endinterface

// File: rtl/loop_debounce.sv
// rtl/loop_debounce.sv - synchronise and debounce the raw loop, pulse on each new car
module loop_debounce
  import sig_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic clear_n,
  input  logic loop,
  output logic arrive
);

  localparam int            CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          loop_s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Arrival fires on the edge that accepts the rising transition so the
  // car counter updates on that same edge.
  assign arrive = loop_s &&
                  (((state == DB_LOW) && (DEBOUNCE == 1)) ||
                   ((state == DB_RISE) && (cnt == DB_LAST)));

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync1  <= 1'b0;
      loop_s <= 1'b0;
    end else begin
      sync1  <= loop;
      loop_s <= sync1;
    end
  end

  // Debounce FSM: a level must hold DEBOUNCE samples before it is accepted.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= DB_LOW;
      cnt   <= '0;
    end else begin
      case (state)
        DB_LOW: begin
          if (loop_s) begin
            if (DEBOUNCE == 1) begin
              state <= DB_HIGH;
            end else begin
              state <= DB_RISE;
              cnt   <= ONE;
            end
          end
        end
        DB_RISE: begin
          if (!loop_s) begin
            state <= DB_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
            if (cnt == DB_LAST) state <= DB_HIGH;
          end
        end
        DB_HIGH: begin
          if (!loop_s) begin
            if (DEBOUNCE == 1) begin
              state <= DB_LOW;
            end else begin
              state <= DB_FALL;
              cnt   <= ONE;
            end
          end
        end
        DB_FALL: begin
          if (loop_s) begin
            state <= DB_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
            if (cnt == DB_LAST) state <= DB_LOW;
          end
        end
        default: begin
          state <= DB_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cntry_car_sensor.sv
// rtl/cntry_car_sensor.sv - country-road car counter feeding X to the signal controller
module cntry_car_sensor
  import sig_pkg::*;
#(
  parameter int DEBOUNCE     = 3,
  parameter int CNT_W        = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  cntry_car_sensor_if.master bus
);

  localparam int               DW      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DR_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]    DR_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             arrive;
  logic             depart;
  logic             green;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             x_q;
  logic             ovf_q;

  loop_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_db (
    .clock   (clock),
    .clear_n (clear_n),
    .loop    (bus.loop),
    .arrive  (arrive)
  );

  // Only GREEN drains; YELLOW and the illegal code behave like RED.
  assign green  = (bus.cntry == GREEN);
  assign depart = green && (drain_q == DR_LAST);

  // Drain timer: counts consecutive GREEN edges, wrapping on each departure.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      drain_q <= '0;
    end else if (!green || depart) begin
      drain_q <= '0;
    end else begin
      drain_q <= drain_q + DR_ONE;
    end
  end

  // Next waiting-car count: saturating up, floor at zero, collision holds.
  always_comb begin
    count_d = count_q;
    if (arrive && !depart && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else if (depart && !arrive && (count_q != '0)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Count, sticky overflow, and X which trails the registered count by one edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
      x_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      x_q     <= (count_q != '0);
      if (arrive && !depart && (count_q == CNT_MAX)) ovf_q <= 1'b1;
    end
  end

  assign bus.car_count = count_q;
  assign bus.X         = x_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cntry_car_sensor.sv
// tb/tb_cntry_car_sensor.sv - scoreboard bench for the country car sensor
module tb_cntry_car_sensor;
  import sig_pkg::*;

  localparam int DEBOUNCE = 3;
  localparam int CNT_W    = 4;
  localparam int DRAIN    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    int val;
    int at;
  } exp_t;

  logic clock = 1'b0;
  logic clear_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  bit   sb_en = 1'b0;
  exp_t sb_q[$];

  int   m_count = 0;
  int   m_tmr = 0;
  bit   m_ovf = 1'b0;

  always #5 clock = ~clock;

  // Edge counter: value seen at a negedge is the number of the last posedge.
  always @(posedge clock) cyc <= cyc + 1;

  cntry_car_sensor_if #(.CNT_W(CNT_W)) bus ();

  cntry_car_sensor #(
    .DEBOUNCE     (DEBOUNCE),
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  task automatic sb_monitor();
    logic [CNT_W-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clock);
      if (sb_en) begin
        n_checks++;
        if (bus.X !== (prev != '0)) begin
          n_fails++;
          $display("FAIL x_follows_count @%0d: X=%b required %b", cyc, bus.X, (prev != '0));
        end
        if (bus.car_count !== prev) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fails++;
            $display("FAIL sb_unexpected @%0d: car_count=%0d required %0d", cyc, bus.car_count, prev);
          end else begin
            e = sb_q.pop_front();
            if (int'(bus.car_count) != e.val || cyc != e.at) begin
              n_fails++;
              $display("FAIL sb_count: car_count=%0d at edge %0d, required %0d at edge %0d",
                       bus.car_count, cyc, e.val, e.at);
            end
          end
        end
      end
      prev = bus.car_count;
    end
  endtask

  task automatic car(input int hold);
    int n;
    bus.loop = 1'b1;
    n = cyc + 1;
    if (hold >= DEBOUNCE) begin
      if (m_count == CNT_MAX) begin
        m_ovf = 1'b1;
      end else begin
        m_count++;
        sb_q.push_back('{m_count, n + DEBOUNCE + 1});
      end
    end
    repeat (hold) @(negedge clock);
    bus.loop = 1'b0;
    repeat (DEBOUNCE + 4) @(negedge clock);
  endtask

  task automatic green(input int k, input logic [1:0] after);
    int g;
    bus.cntry = GREEN;
    g = cyc + 1;
    for (int i = 0; i < k; i++) begin
      m_tmr++;
      if (m_tmr == DRAIN) begin
        m_tmr = 0;
        if (m_count > 0) begin
          m_count--;
          sb_q.push_back('{m_count, g + i});
        end
      end
    end
    repeat (k) @(negedge clock);
    bus.cntry = after;
    m_tmr = 0;
  endtask

  task automatic test_reset();
    clear_n = 1'b1;
    #1 clear_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.X !== 1'b0) begin n_fails++; $display("FAIL reset_x: X=%b required 0", bus.X); end
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL reset_count: car_count=%0d required 0", bus.car_count); end
    if (bus.overflow !== 1'b0) begin n_fails++; $display("FAIL reset_ovf: overflow=%b required 0", bus.overflow); end
    if (dut.u_db.state !== DB_LOW) begin n_fails++; $display("FAIL reset_fsm: state=%0d required %0d", dut.u_db.state, DB_LOW); end
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    sb_en = 1'b1;
  endtask

  task automatic test_glitch();
    car(2);
    n_checks += 2;
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL glitch_count: car_count=%0d required 0", bus.car_count); end
    if (bus.X !== 1'b0) begin n_fails++; $display("FAIL glitch_x: X=%b required 0", bus.X); end
  endtask

  task automatic test_single_car();
    car(10);
    n_checks += 2;
    if (int'(bus.car_count) != 1) begin n_fails++; $display("FAIL single_count: car_count=%0d required 1", bus.car_count); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL single_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  task automatic test_drain();
    car(4);
    car(4);
    n_checks++;
    if (int'(bus.car_count) != 3) begin n_fails++; $display("FAIL drain_start: car_count=%0d required 3", bus.car_count); end
    green(12, RED);
    repeat (2) @(negedge clock);
    n_checks += 3;
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL drain_count: car_count=%0d required 0", bus.car_count); end
    if (bus.X !== 1'b0) begin n_fails++; $display("FAIL drain_x: X=%b required 0", bus.X); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL drain_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  task automatic test_yellow();
    car(4);
    green(3, YELLOW);
    repeat (4) @(negedge clock);
    n_checks++;
    if (int'(bus.car_count) != 1) begin n_fails++; $display("FAIL yellow_hold: car_count=%0d required 1", bus.car_count); end
    bus.cntry = 2'd3;
    repeat (3) @(negedge clock);
    n_checks++;
    if (int'(bus.car_count) != 1) begin n_fails++; $display("FAIL illegal_hold: car_count=%0d required 1", bus.car_count); end
    green(4, RED);
    repeat (2) @(negedge clock);
    n_checks += 3;
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL yellow_restart: car_count=%0d required 0", bus.car_count); end
    if (bus.X !== 1'b0) begin n_fails++; $display("FAIL yellow_x: X=%b required 0", bus.X); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL yellow_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  task automatic test_collision();
    car(4);
    car(4);
    bus.loop = 1'b1;
    @(negedge clock);
    bus.cntry = GREEN;
    repeat (4) @(negedge clock);
    bus.cntry = RED;
    @(negedge clock);
    bus.loop = 1'b0;
    repeat (DEBOUNCE + 4) @(negedge clock);
    n_checks += 2;
    if (int'(bus.car_count) != 2) begin n_fails++; $display("FAIL collision_count: car_count=%0d required 2", bus.car_count); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL collision_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  task automatic test_saturation();
    repeat (13) car(4);
    n_checks += 2;
    if (int'(bus.car_count) != CNT_MAX) begin n_fails++; $display("FAIL sat_full: car_count=%0d required %0d", bus.car_count, CNT_MAX); end
    if (bus.overflow !== 1'b0) begin n_fails++; $display("FAIL sat_noovf: overflow=%b required 0", bus.overflow); end
    car(4);
    n_checks += 2;
    if (int'(bus.car_count) != CNT_MAX) begin n_fails++; $display("FAIL sat_hold: car_count=%0d required %0d", bus.car_count, CNT_MAX); end
    if (bus.overflow !== m_ovf) begin n_fails++; $display("FAIL sat_ovf: overflow=%b required %b", bus.overflow, m_ovf); end
    green(4, RED);
    repeat (2) @(negedge clock);
    n_checks += 3;
    if (int'(bus.car_count) != m_count) begin n_fails++; $display("FAIL sat_drain: car_count=%0d required %0d", bus.car_count, m_count); end
    if (bus.overflow !== 1'b1) begin n_fails++; $display("FAIL sat_sticky: overflow=%b required 1", bus.overflow); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL sat_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    sb_en = 1'b0;
    @(posedge clock);
    #2 clear_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.X !== 1'b0) begin n_fails++; $display("FAIL areset_x: X=%b required 0", bus.X); end
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL areset_count: car_count=%0d required 0", bus.car_count); end
    if (bus.overflow !== 1'b0) begin n_fails++; $display("FAIL areset_ovf: overflow=%b required 0", bus.overflow); end
    if (dut.u_db.state !== DB_LOW) begin n_fails++; $display("FAIL areset_fsm: state=%0d required %0d", dut.u_db.state, DB_LOW); end
    m_count = 0;
    m_tmr = 0;
    m_ovf = 1'b0;
    sb_q.delete();
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    sb_en = 1'b1;
    // Reset partway through a debounce: the partial car must be forgotten.
    bus.loop = 1'b1;
    repeat (3) @(negedge clock);
    clear_n = 1'b0;
    bus.loop = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    repeat (8) @(negedge clock);
    n_checks++;
    if (bus.car_count !== '0) begin n_fails++; $display("FAIL abandon_count: car_count=%0d required 0", bus.car_count); end
    car(5);
    repeat (2) @(negedge clock);
    n_checks += 2;
    if (int'(bus.car_count) != 1) begin n_fails++; $display("FAIL restart_count: car_count=%0d required 1", bus.car_count); end
    if (sb_q.size() != 0) begin n_fails++; $display("FAIL restart_pending: %0d expected changes not seen, required 0", sb_q.size()); end
  endtask

  initial begin
    clear_n   = 1'b1;
    bus.loop  = 1'b0;
    bus.cntry = RED;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_glitch();
    test_single_car();
    test_drain();
    test_yellow();
    test_collision();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
